// File: rtl/mul128_pkg.sv
// Shared types and defaults for the shared 128x128 multiplier front end.
package mul128_pkg;

  localparam int unsigned WIDTH_DEF   = 128;
  localparam int unsigned TIMEOUT_DEF = 4096;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with a pointer that moves past the winner on accept.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  int unsigned    sel;
  logic           found;

  // Requester at rotational distance 0 from ptr_q has the highest priority.
  always_comb begin
    gnt_o = '0;
    sel   = 0;
    found = 1'b0;
    for (int unsigned d = 0; d < NREQ; d++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (((i + NREQ - 32'(ptr_q)) % NREQ) == d)) begin
          found    = 1'b1;
          sel      = i;
          gnt_o[i] = en_i;
        end
      end
    end
    gnt_idx_o = IDW'(sel);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = IDW'((sel + 1) % NREQ);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mul128_arbiter.sv
// Round-robin front end that shares one sequential multiplier between NREQ
// clients and returns each product on a tagged response port, with a watchdog.
module mul128_arbiter
  import mul128_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  rsp_err,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_ain,
  output logic [WIDTH-1:0]      mul_bin,
  input  logic [2*WIDTH-1:0]    mul_yout,
  input  logic                  mul_done,
  output logic                  busy
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     tag_q;
  logic               grant_en, transfer, timeout;
  logic [CW-1:0]      wd_q;
  logic [WIDTH-1:0]   sel_a, sel_b, ain_q, bin_q;
  logic [2*WIDTH-1:0] data_q;
  logic               err_q;

  // A lingering mul_done from the previous operation must not overlap a new start.
  assign grant_en = (state_q == IDLE) && !mul_done;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .en_i      (grant_en),
    .req_i     (req_valid),
    .accept_i  (transfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign transfer  = |(req_valid & gnt);
  assign timeout   = (TIMEOUT != 0) && (wd_q == CW'(TIMEOUT - 1));

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = BUSY;
      BUSY:    if (mul_done || timeout) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state_q == BUSY);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ain_q  <= '0;
      bin_q  <= '0;
      tag_q  <= '0;
      wd_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (transfer) begin
        ain_q <= sel_a;
        bin_q <= sel_b;
        tag_q <= gnt_idx;
        wd_q  <= '0;
      end
      if (state_q == BUSY) begin
        wd_q <= wd_q + CW'(1);
        if (mul_done) begin
          data_q <= mul_yout;
          err_q  <= 1'b0;
        end else if (timeout) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign mul_ain  = ain_q;
  assign mul_bin  = bin_q;
  assign rsp_id   = tag_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_mul128_arbiter.sv
// Scoreboard bench for mul128_arbiter with a behavioural sequential multiplier.
module tb_mul128_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned IDW   = 2;
  localparam int          TO    = 16;
  localparam int          LAT   = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  rsp_err;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_ain, mul_bin;
  logic [2*WIDTH-1:0]    mul_yout;
  logic                  mul_done;
  logic                  busy;

  mul128_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .IDW     (IDW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_ain   (mul_ain),
    .mul_bin   (mul_bin),
    .mul_yout  (mul_yout),
    .mul_done  (mul_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   id;
    logic [255:0] data;
    logic         err;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-requester operand queues (ring buffers): stimulus writes, monitor consumes.
  logic [127:0] op_a [4][16];
  logic [127:0] op_b [4][16];
  int           wr [4] = '{0, 0, 0, 0};
  int           rd [4] = '{0, 0, 0, 0};
  logic         hang;

  task automatic push_op(input int i, input logic [127:0] a, input logic [127:0] b);
    op_a[i][wr[i] % 16] = a;
    op_b[i][wr[i] % 16] = b;
    wr[i]++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rd[i] != wr[i]) begin
        req_valid[i]          = 1'b1;
        req_a[i*128 +: 128]   = op_a[i][rd[i] % 16];
        req_b[i*128 +: 128]   = op_b[i][rd[i] % 16];
      end else begin
        req_valid[i]          = 1'b0;
        req_a[i*128 +: 128]   = '0;
        req_b[i*128 +: 128]   = '0;
      end
    end
  end

  logic m_run;
  int   m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_run    <= 1'b0;
      m_cnt    <= 0;
      mul_done <= 1'b0;
      mul_yout <= '0;
    end else begin
      mul_done <= 1'b0;
      if (!mul_start) m_run <= 1'b0;
      else if (!m_run) begin
        if (!mul_done) begin
          m_run    <= 1'b1;
          m_cnt    <= LAT - 1;
          mul_yout <= {128'b0, mul_ain} * {128'b0, mul_bin};
        end
      end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (!hang && !mul_done) mul_done <= 1'b1;
    end
  end

  function automatic logic [3:0] pick(input logic [3:0] v, input int p);
    logic [3:0] g;
    logic       f;
    g = '0;
    f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!f && v[(p + k) % 4]) begin
        g[(p + k) % 4] = 1'b1;
        f = 1'b1;
      end
    end
    return g;
  endfunction

  exp_t         sb [$];
  int           gorder [$];
  int           m_ptr = 0;
  logic         m_busy = 1'b0;
  logic         m_rvalid = 1'b0;
  logic         m_done_seen = 1'b0;
  logic         cur_hang = 1'b0;
  int           m_since = 0;
  exp_t         e;
  logic [127:0] ta, tb_;

  always @(negedge clk) begin
    if (rst) begin
      m_ptr       = 0;
      m_busy      = 1'b0;
      m_rvalid    = 1'b0;
      m_done_seen = 1'b0;
      m_since     = 0;
      sb.delete();
    end else begin
      if (!m_busy && !mul_done)
        check_eq("grant", 256'(req_ready), 256'(pick(req_valid, m_ptr)));
      else if (m_busy) begin
        check_eq("no_grant_busy", 256'(req_ready), 256'(0));
        m_since++;
        if (m_since == 1) check_eq("start_lat", 256'(mul_start), 256'(1));
        if (m_done_seen) begin
          check_eq("rsp_after_done", 256'(rsp_valid), 256'(1));
          check_eq("start_low", 256'(mul_start), 256'(0));
          m_done_seen = 1'b0;
        end
        if (mul_done) m_done_seen = 1'b1;
        if (cur_hang && m_since == TO)     check_eq("to_early", 256'(rsp_valid), 256'(0));
        if (cur_hang && m_since == TO + 1) check_eq("to_rsp", 256'(rsp_valid), 256'(1));
      end
      check_eq("busy", 256'(busy), 256'(m_busy));
      if (m_rvalid) check_eq("rsp_hold", 256'(rsp_valid), 256'(1));
      if (rsp_valid) begin
        check_eq("rsp_pending", 256'(sb.size() != 0), 256'(1));
        if (sb.size() != 0) begin
          check_eq("rsp_id", 256'(rsp_id), 256'(sb[0].id));
          check_eq("rsp_data", rsp_data, sb[0].data);
          check_eq("rsp_err", 256'(rsp_err), 256'(sb[0].err));
        end
        if (rsp_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_rvalid = 1'b0;
          m_busy   = 1'b0;
        end else m_rvalid = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          ta     = op_a[i][rd[i] % 16];
          tb_    = op_b[i][rd[i] % 16];
          e.id   = 2'(i);
          e.err  = hang;
          e.data = hang ? 256'b0 : {128'b0, ta} * {128'b0, tb_};
          sb.push_back(e);
          gorder.push_back(i);
          rd[i]++;
          m_ptr       = (i + 1) % 4;
          m_busy      = 1'b1;
          m_since     = 0;
          m_done_seen = 1'b0;
          cur_hang    = hang;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic drained();
    logic d;
    d = (sb.size() == 0) && !m_busy;
    for (int i = 0; i < 4; i++) if (rd[i] != wr[i]) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 2000 && !drained()) begin
      step(1);
      n++;
    end
    check_eq(tag, 256'(drained()), 256'(1));
    step(1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
    check_eq({tag, "_rsp_id"}, 256'(rsp_id), 256'(0));
    check_eq({tag, "_rsp_data"}, rsp_data, 256'(0));
    check_eq({tag, "_rsp_err"}, 256'(rsp_err), 256'(0));
    check_eq({tag, "_mul_start"}, 256'(mul_start), 256'(0));
    check_eq({tag, "_mul_ain"}, 256'(mul_ain), 256'(0));
    check_eq({tag, "_mul_bin"}, 256'(mul_bin), 256'(0));
    check_eq({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  int exp_t2 [5] = '{0, 1, 2, 3, 0};
  int exp_t5 [3] = '{1, 0, 2};

  initial begin
    int n;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    hang      = 1'b0;
    step(3);
    check_zero("reset");
    check_eq("reset_req_ready", 256'(req_ready), 256'(0));
    rst = 1'b0;
    step(2);

    // Single request from requester 0
    push_op(0, 128'h0111_0000_0000_0000_0000_0000_1010_0000,
               128'h0000_0000_0000_1111_1111_0000_0000_0000);
    wait_idle("t1_wait");
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);

    // All four requesting, pointer at 0
    gorder.delete();
    for (int i = 0; i < 4; i++) push_op(i, rnd128(), rnd128());
    push_op(0, rnd128(), rnd128());
    wait_idle("t2_wait");
    check_eq("t2_count", 256'(gorder.size()), 256'(5));
    for (int i = 0; i < 5 && i < gorder.size(); i++) check_eq("t2_order", 256'(gorder[i]), 256'(exp_t2[i]));

    // Backpressure on the response port
    rsp_ready = 1'b0;
    push_op(1, rnd128(), rnd128());
    push_op(2, rnd128(), rnd128());
    step(LAT + 30);
    check_eq("bp_rsp_valid", 256'(rsp_valid), 256'(1));
    check_eq("bp_req_ready", 256'(req_ready), 256'(0));
    rsp_ready = 1'b1;
    wait_idle("t3_wait");

    // Multiplier that never completes
    hang = 1'b1;
    push_op(3, rnd128(), rnd128());
    wait_idle("t4_wait");
    hang = 1'b0;
    push_op(0, rnd128(), rnd128());
    wait_idle("t4b_wait");

    // Reset while BUSY
    gorder.delete();
    push_op(1, rnd128(), rnd128());
    n = 0;
    while (n < 50 && !m_busy) begin
      step(1);
      n++;
    end
    check_eq("t5_busy", 256'(m_busy), 256'(1));
    step(1);
    push_op(0, rnd128(), rnd128());
    push_op(2, rnd128(), rnd128());
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_zero("rst_busy");
    wait_idle("t5_wait");
    check_eq("t5_count", 256'(gorder.size()), 256'(3));
    for (int i = 0; i < 3 && i < gorder.size(); i++) check_eq("t5_order", 256'(gorder[i]), 256'(exp_t5[i]));

    // Operand extremes
    push_op(2, '1, '1);
    push_op(3, '0, rnd128());
    wait_idle("t6_wait");

    check_eq("sb_empty", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul128_arbiter.md
Name: mul128_arbiter

Overview:
- Shares one sequential 128x128 multiplier (start/done, 256-bit product) between NREQ requesters.
- Round-robin arbiter plus sequencer: accepts one operand pair per grant, drives the multiplier, and returns the product to the granted requester through a single tagged response port.
- Sits between the client blocks and the multiplier instance.
- Adds a watchdog that flags and recovers from a multiplier that never completes.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 128, operand width; product is 2*WIDTH.
- IDW, 2, requester tag width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 4096, maximum cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high per cycle.
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  2*WIDTH  product.
- rsp_err  out  1  set with rsp_valid when the operation timed out; rsp_data is 0 in that case.
- mul_start  out  1  multiplier start, level.
- mul_ain  out  WIDTH  multiplier operand A.
- mul_bin  out  WIDTH  multiplier operand B.
- mul_yout  in  2*WIDTH  multiplier product.
- mul_done  in  1  multiplier completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, and every output is 0 (req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_start, mul_ain, mul_bin, busy). Reset mid-operation abandons the operation without producing a response.
- The reset input is synchronous, active-high; the clock input is clk.
- IDLE state:
  - req_ready is combinational: one-hot for the first req_valid at or after rr_ptr, wrapping modulo NREQ.
  - Zero when no request is pending or mul_done is still high.
- Transfer: occurs on the cycle req_valid[i] & req_ready[i].
  - Register mul_ain/mul_bin from slice i and the tag i.
  - Set rr_ptr = (i+1) mod NREQ.
  - Go to BUSY.
- BUSY state:
  - mul_start=1; operands held stable; watchdog counter counts up from 0.
  - On mul_done=1: register mul_yout into rsp_data, rsp_err=0, mul_start=0 next cycle, go to RESP.
  - If the counter reaches TIMEOUT-1 without mul_done: rsp_data=0, rsp_err=1, go to RESP.
  - If mul_done and timeout occur in the same cycle, mul_done wins.
- RESP state:
  - rsp_valid=1 and rsp_id=tag; rsp_data and rsp_err stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - mul_start stays 0.
- Handshake rules:
  - A requester holds req_valid and its operands until ready.
  - The controller never deasserts rsp_valid without a handshake.
- Latency:
  - Transfer to mul_start is 1 cycle.
  - mul_done to rsp_valid is 1 cycle.
  - Minimum back-to-back issue interval is (multiplier latency + 3) cycles when rsp_ready is tied high.
- Fairness: after each grant, the granted index has the lowest priority; no requester waits more than NREQ-1 grants.
- Only one operation is in flight; requests arriving while BUSY or in RESP wait, with req_ready=0.
- Operand packing: an index >= NREQ is never granted. The tag width is IDW; unused tag values never appear.

Decomposition:
- Package mul128_pkg holds:
  - WIDTH default;
  - the state enum (IDLE, BUSY, RESP);
  - the state encoding constants;
  - the TIMEOUT default.
- Sub-module rr_arbiter (parameter NREQ): combinational one-hot grant from the request vector and rr_ptr, plus the registered pointer update on accept. Reusable for other shared units.

Test Plan:
1. Single request: req_valid[0] with a=128'h0111_0000_0000_0000_0000_0000_1010_0000, b=128'h0000_0000_0000_1111_1111_0000_0000_0000 -> mul_start high 1 cycle after transfer; rsp_id=0, rsp_data=a*b, rsp_err=0, 1 cycle after mul_done.
2. All four requesting continuously with rr_ptr=0 -> grant order 0,1,2,3,0, one response each, tags match; no grant while busy.
3. Backpressure: rsp_ready low 20 cycles -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0 for all requesters; transfer resumes the cycle after the handshake.
4. Timeout: TIMEOUT=16, multiplier model never asserts done -> rsp_valid at cycle 16 of BUSY with rsp_err=1 and rsp_data=0; the next request is served normally.
5. Reset in BUSY: assert rst for 1 cycle -> next cycle all outputs 0, state IDLE, no response emitted; rr_ptr=0, so requester 0 is granted first.
6. Operand extremes: a=b=all ones -> rsp_data=256'hFFFF...FFFE0000...0001; a=0 -> rsp_data=0.
